srq_flow: RTL and testbench
===========================

Name: srq_flow

Overview:
- Parametrised successor of the team's shift-register queue: a collapsing shift-register FIFO for wide, low-depth buffering between controller stages (e.g. command and write-data staging in the DRAM controller).
- Generalised to any DEPTH >= 2, with full valid/ready handshakes on both sides, an occupancy count, a programmable almost-full flag and a synchronous flush.
- Bubbles collapse: each entry advances toward the tail whenever the next stage is empty or is itself advancing.

Parameters:
- WIDTH, 1024: data word width in bits.
- DEPTH, 4: number of stages. Legal range is DEPTH >= 2.
- AF_THRESH, DEPTH-1: almost_full asserts when count >= AF_THRESH. Legal range is 1..DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of all entries.
- in_valid  in  1  producer has a word.
- in_ready  out  1  queue can accept a word this cycle.
- in_data  in  WIDTH  producer word.
- out_valid  out  1  tail stage holds a valid word.
- out_ready  in  1  consumer takes the tail word.
- out_data  out  WIDTH  tail stage word (stage DEPTH-1).
- count  out  $clog2(DEPTH+1)  occupancy.
- almost_full  out  1  count >= AF_THRESH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Storage:
  - valid[0..DEPTH-1] are reset to 0 by rst.
  - data[0..DEPTH-1] have no reset and load only when their stage loads.
  - Stage 0 is the head; stage DEPTH-1 is the tail.
- Reset values: in_ready=1, out_valid=0, count=0, empty=1, full=0, almost_full=0 (1 only if AF_THRESH would be 0, which is illegal). out_data is undefined.
- Move terms (combinational):
  - mv[DEPTH-1] = valid[DEPTH-1] & out_ready & ~flush
  - mv[i] = valid[i] & (~valid[i+1] | mv[i+1]), for i < DEPTH-1
- Head side:
  - in_ready = ~flush & (~valid[0] | mv[0]).
  - accept = in_valid & in_ready.
  - in_ready is combinational from out_ready; this path is intentional.
- Next state:
  - Stage 0: valid[0] <= accept ? 1 : (mv[0] ? 0 : valid[0]), and data[0] loads in_data on accept.
  - Stage i > 0: valid[i] <= mv[i-1] ? 1 : (mv[i] ? 0 : valid[i]), and data[i] loads data[i-1] on mv[i-1].
- Ordering: strict FIFO. No entry overtakes another.
- Outputs: out_valid = valid[DEPTH-1] & ~flush. A pop is out_valid & out_ready.
- Count: count <= count + accept - pop. Simultaneous accept and pop leaves count unchanged.
- Latency without the optional feature: a word accepted at edge t into an empty queue is visible at the tail (out_valid=1) after edge t+DEPTH-1, i.e. DEPTH cycles after in_valid was sampled.
- Full with out_ready=1: in_ready=1 in the same cycle (ripple). A push and a pop both complete and count stays DEPTH.
- Full with out_ready=0: in_ready=0. in_valid is held by the producer and is not an error.
- Empty with out_ready=1: no pop occurs and count stays 0.
- Flush:
  - Highest priority.
  - During the flush cycle, in_ready=0 and out_valid=0, so no transfers occur.
  - At the next edge all valid bits clear and count=0.
- Reset mid-operation: all valid bits and count clear immediately (asynchronously). In-flight words are discarded.

Optional Feature:
- Macro: SRQ_FALL_THROUGH_EN.
- Defined:
  - When accept=1 and all valid bits are 0, in_data is written directly into stage DEPTH-1 and valid[DEPTH-1] is set; stage 0 is not loaded.
  - Tail latency from an empty queue becomes 1 cycle.
  - Ordering is preserved because the queue is empty.
  - All other cycles behave as in the base design.
- Undefined: accepted words always enter stage 0 and reach the tail in DEPTH cycles.

Test Plan:
- Reset with rst=0, then release; hold out_ready=0 -> in_ready=1, out_valid=0, count=0, empty=1, full=0, almost_full=0.
- Push one word 0xA5 into an empty queue (DEPTH=4, feature off) -> out_valid rises 4 cycles after the push cycle with out_data=0xA5. With the feature on, it rises the next cycle.
- Push 1,2,3,4 with out_ready=0:
  - almost_full=1 at count 3; full=1 and in_ready=0 at count 4.
  - Then out_ready=1 -> pops 1,2,3,4 in order and empty=1 after the fourth.
- Full queue, in_valid=1 with 5 and out_ready=1 for one cycle -> pops 1, accepts 5, count stays 4, and 5 is the last word out.
- Three words queued, flush=1 for one cycle while in_valid=1 and out_ready=1 -> no transfer that cycle; next cycle count=0, out_valid=0, in_ready=1.
- Two words queued and mid-shift, assert rst=0 asynchronously -> valid bits and count clear without a clock edge. After release, push 7 -> 7 is the first word out.

Source files
------------

// File: rtl/srq_flow_if.sv
// srq_flow_if: handshake and status bundle for the srq_flow collapsing queue.
// master = producer/consumer side, slave = the queue itself.
interface srq_flow_if #(
    parameter int unsigned WIDTH = 1024,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;
    logic             almost_full;
    logic             full;
    logic             empty;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count, almost_full, full, empty
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count, almost_full, full, empty
    );
endinterface

// File: rtl/srq_flow.sv
// srq_flow: collapsing shift-register FIFO. Stage 0 is the head, stage DEPTH-1 the tail.
// Entries advance whenever the next stage is empty or itself advancing, so bubbles collapse.
// Optional macro SRQ_FALL_THROUGH_EN: a word accepted into a completely empty queue is
// written straight into the tail stage (1-cycle latency instead of DEPTH).
module srq_flow #(
    parameter int unsigned WIDTH     = 1024,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned AF_THRESH = DEPTH - 1
) (
    input logic       clk,
    input logic       rst,
    srq_flow_if.slave q
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] mv;
    logic [DEPTH-1:0] ld;
    logic [WIDTH-1:0] data_q   [DEPTH];
    logic [WIDTH-1:0] data_src [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic             accept;
    logic             pop;
    logic             ft;

    // Move terms ripple from the tail toward the head.
    always_comb begin
        mv = '0;
        mv[DEPTH-1] = valid_q[DEPTH-1] & q.out_ready & ~q.flush;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            mv[i] = valid_q[i] & (~valid_q[i+1] | mv[i+1]);
        end
    end

    // in_ready is combinational from out_ready through the move chain by design.
    assign q.in_ready  = ~q.flush & (~valid_q[0] | mv[0]);
    assign accept      = q.in_valid & q.in_ready;
    assign q.out_valid = valid_q[DEPTH-1] & ~q.flush;
    assign pop         = q.out_valid & q.out_ready;
    assign q.out_data  = data_q[DEPTH-1];

`ifdef SRQ_FALL_THROUGH_EN
    assign ft = accept & ~(|valid_q);
`else
    assign ft = 1'b0;
`endif

    // Per-stage valid/load next state; flush overrides everything.
    always_comb begin
        valid_d = valid_q;
        ld      = '0;
        data_src[0] = q.in_data;
        for (int i = 1; i < DEPTH; i++) begin
            data_src[i] = data_q[i-1];
        end
        if (ft) begin
            data_src[DEPTH-1] = q.in_data;
        end

        if (q.flush) begin
            valid_d = '0;
        end else begin
            ld[0] = accept & ~ft;
            for (int i = 1; i < DEPTH; i++) begin
                ld[i] = mv[i-1];
            end
            ld[DEPTH-1] = ld[DEPTH-1] | ft;
            for (int i = 0; i < DEPTH; i++) begin
                if (ld[i]) begin
                    valid_d[i] = 1'b1;
                end else if (mv[i]) begin
                    valid_d[i] = 1'b0;
                end
            end
        end
    end

    // Occupancy follows the accepted/popped handshakes.
    always_comb begin
        if (q.flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + {{(CW-1){1'b0}}, accept} - {{(CW-1){1'b0}}, pop};
        end
    end

    // Valid bits and count: asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    // Data stages carry no reset; each loads only when its stage loads.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (ld[i]) begin
                data_q[i] <= data_src[i];
            end
        end
    end

    assign q.count       = count_q;
    assign q.empty       = (count_q == '0);
    assign q.full        = (count_q == CW'(DEPTH));
    assign q.almost_full = (count_q >= CW'(AF_THRESH));
endmodule

// File: tb/tb_srq_flow.sv
// tb_srq_flow: scoreboard bench for srq_flow (DEPTH=4, WIDTH=32, AF_THRESH=3).
module tb_srq_flow;
    localparam int unsigned W  = 32;
    localparam int unsigned D  = 4;
    localparam int unsigned AF = 3;
`ifdef SRQ_FALL_THROUGH_EN
    localparam int EXP_LAT = 0;
`else
    localparam int EXP_LAT = D - 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks   = 0;
    int failures = 0;
    logic [W-1:0] mq[$];
    logic [W-1:0] last_pop = '0;

    srq_flow_if #(.WIDTH(W), .DEPTH(D)) q_if ();

    srq_flow #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF)) dut (
        .clk (clk),
        .rst (rst),
        .q   (q_if)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: status rules from the model occupancy; pops compared against scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            chk("count", 32'(q_if.count), 32'(mq.size()));
            chk("empty", 32'(q_if.empty), 32'(mq.size() == 0));
            chk("full", 32'(q_if.full), 32'(mq.size() == D));
            chk("almost_full", 32'(q_if.almost_full), 32'(mq.size() >= AF));
            chk("in_ready", 32'(q_if.in_ready),
                32'(!q_if.flush && (mq.size() < D || q_if.out_ready)));
            if (q_if.flush) chk("flush_out_valid", 32'(q_if.out_valid), 32'd0);
            if (q_if.out_valid && q_if.out_ready) begin
                if (mq.size() == 0) begin
                    chk("pop_when_empty", 32'd1, 32'd0);
                end else begin
                    chk("pop_data", q_if.out_data, mq.pop_front());
                    last_pop = q_if.out_data;
                end
            end
        end
    end

    // One cycle of stimulus; starts and ends 1 time unit after a rising edge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic ordy, input logic fl);
        logic acc;
        q_if.in_valid  = v;
        q_if.in_data   = d;
        q_if.out_ready = ordy;
        q_if.flush     = fl;
        @(negedge clk);
        acc = v & q_if.in_ready;
        @(posedge clk);
        if (fl) mq.delete();
        else if (acc) mq.push_back(d);
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && mq.size() != 0; n++) step(1'b0, '0, 1'b1, 1'b0);
        chk("drain_done", 32'(mq.size()), 32'd0);
        chk("drain_empty", 32'(q_if.empty), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        q_if.in_valid  = 1'b0;
        q_if.in_data   = '0;
        q_if.out_ready = 1'b0;
        q_if.flush     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(q_if.in_ready), 32'd1);
        chk("rst_out_valid", 32'(q_if.out_valid), 32'd0);
        chk("rst_count", 32'(q_if.count), 32'd0);
        chk("rst_empty", 32'(q_if.empty), 32'd1);
        chk("rst_full", 32'(q_if.full), 32'd0);
        chk("rst_af", 32'(q_if.almost_full), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single-word latency from empty.
        step(1'b1, 32'hA5, 1'b0, 1'b0);
        k = 0;
        while (!q_if.out_valid && k < 10) begin
            step(1'b0, '0, 1'b0, 1'b0);
            k++;
        end
        chk("latency", 32'(k), 32'(EXP_LAT));
        chk("latency_data", q_if.out_data, 32'hA5);
        drain();

        // Fill to full with consumer stalled.
        for (int w = 1; w <= 4; w++) begin
            step(1'b1, W'(w), 1'b0, 1'b0);
            if (w == 3) begin
                chk("af_at3", 32'(q_if.almost_full), 32'd1);
                chk("notfull_at3", 32'(q_if.full), 32'd0);
            end
        end
        chk("full_at4", 32'(q_if.full), 32'd1);
        chk("in_ready_full", 32'(q_if.in_ready), 32'd0);
        // Push and pop together while full.
        step(1'b1, 32'd5, 1'b1, 1'b0);
        chk("count_full_pushpop", 32'(q_if.count), 32'd4);
        chk("first_pop_1", last_pop, 32'd1);
        drain();
        chk("last_word_5", last_pop, 32'd5);

        // Flush with both handshakes requested.
        for (int w = 0; w < 3; w++) step(1'b1, W'(32'h30 + w), 1'b0, 1'b0);
        step(1'b1, 32'h99, 1'b1, 1'b1);
        q_if.flush    = 1'b0;
        q_if.in_valid = 1'b0;
        #1;
        chk("flush_count", 32'(q_if.count), 32'd0);
        chk("flush_out_valid_after", 32'(q_if.out_valid), 32'd0);
        chk("flush_in_ready_after", 32'(q_if.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-shift.
        step(1'b1, 32'd11, 1'b0, 1'b0);
        step(1'b1, 32'd12, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("arst_count", 32'(q_if.count), 32'd0);
        chk("arst_empty", 32'(q_if.empty), 32'd1);
        chk("arst_out_valid", 32'(q_if.out_valid), 32'd0);
        mq.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        step(1'b1, 32'd7, 1'b0, 1'b0);
        drain();
        chk("after_arst_first", last_pop, 32'd7);

        // Randomised traffic.
        for (int n = 0; n < 1500; n++) begin
            step(($urandom % 10) < 6, W'($urandom), ($urandom % 2) == 1, ($urandom % 50) == 0);
        end
        q_if.flush = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
